gsim_job_scheduler: RTL and testbench
=====================================

// Module: gsim_job_scheduler
// PURPOSE
//  Front-end controller for the 16-unknown Gauss-Seidel solver core. Arbitrates NUM_REQ requesters
//  round-robin and fetches one 16-word b vector per job into a staging buffer. Feeds the core in its
//  interleaved load order, waits for it, and returns the 16 results tagged with requester id and x index.
//  Staging is decoupled: the next job is fetched while the core computes.
// PARAMETERS
//  NUM_REQ  4     number of requesters (2..8)
//  ID_W     2     requester id width, >= clog2(NUM_REQ)
//  TIMEOUT  2048  max cycles in C_WAIT before abort (used only when GSIM_SCHED_TIMEOUT_EN is defined)
// PORTS
//  clk             in   1          clock, all logic on rising edge
//  reset           in   1          asynchronous, active-high reset
//  req             in   NUM_REQ    per-requester job request, held high until granted
//  req_data        in   NUM_REQ*16 per-requester b word (signed Q15.0), slice i = [16*i+15:16*i]
//  grant           out  NUM_REQ    one-hot, high for the whole fetch of the granted job
//  req_pop         out  NUM_REQ    one-cycle strobe: current word consumed, present next word next cycle
//  core_reset      out  1          reset pulse to solver core (abort path)
//  core_in_en      out  1          core load strobe
//  core_b_in       out  16         core b word
//  core_out_valid  in   1          core result strobe (16 consecutive cycles)
//  core_x_out      in   32         core result word (signed Q16.16)
//  res_valid       out  1          result strobe
//  res_id          out  ID_W       requester id of result
//  res_idx         out  4          natural x index 0..15 of result
//  res_x           out  32         result value
//  busy            out  1          high if a job is staged, in core, or draining
//  err             out  1          one-cycle abort pulse
// BEHAVIOUR
//  Reset: all outputs 0; both FSMs idle; round-robin pointer = 0; buffer marked empty.
//  Fetch FSM F_IDLE -> F_FILL -> F_FULL:
//   F_IDLE & buffer empty & |req: grant lowest-index requester at/after pointer; pointer := winner+1 (mod NUM_REQ).
//   F_FILL: 16 cycles; cycle k: buf[k] <= req_data slice, req_pop[winner]=1. Natural order b0..b15.
//   Deasserting req mid-fill is ignored; the fill completes. The grant drops on the cycle after the 16th pop.
//   F_FULL: holds until core FSM takes the buffer, then F_IDLE (next grant possible the following cycle).
//  Core FSM C_IDLE -> C_FEED -> C_WAIT -> C_DRAIN -> C_IDLE:
//   C_IDLE & F_FULL: latch job id, enter C_FEED; buffer is released at end of C_FEED.
//   C_FEED: 16 cycles, core_in_en=1, word k = buf[{k[1:0],k[3:2]}] (order 0,4,8,12,1,5,...).
//   C_WAIT: until core_out_valid=1.
//   C_DRAIN: out_valid cycle k -> next cycle res_valid=1, res_idx={k[1:0],k[3:2]}, res_x=core_x_out, res_id=job id.
//   After 16th result: C_IDLE. A full buffer starts C_FEED the very next cycle.
//  Latency: result 0 appears 1 cycle after the core's first out_valid.
//  core_out_valid outside C_WAIT/C_DRAIN: ignored, no res_valid.
//  Async reset mid-job: both FSMs idle, job lost, no res_valid; requesters re-request.
//  busy = (fetch != F_IDLE) | (core != C_IDLE) | res_valid.
// CONFIGURATION
//  GSIM_SCHED_TIMEOUT_EN defined:
//   16-bit watchdog, cleared on entering C_WAIT and counting in C_WAIT.
//   At TIMEOUT: err=1 and core_reset=1 for one cycle, job dropped (no results), core FSM -> C_IDLE.
//   Staged buffer is untouched.
//  Not defined: C_WAIT waits indefinitely; err and core_reset tied 0; no watchdog logic.
// TESTING
//  1 single job: req=4'b0001, words 1..16 -> grant 0001 for 16 cycles; core sees 1,5,9,13,2,...; 16 res id=0 idx 0..15.
//  2 fairness: req=4'b1111 held, 8 jobs -> grant order 0,1,2,3,0,1,2,3.
//  3 overlap: job A in C_WAIT while req[2]=1 -> B fetched, F_FULL held; B fed cycle after A's 16th result.
//  4 index map: core_x_out = 100+k for k-th out_valid -> res_idx seq 0,4,8,12,1,...,15 paired with 100..115.
//  5 timeout (macro on, TIMEOUT=64): core never valid -> err+core_reset pulse 64 cycles into C_WAIT, busy drops if no staged job.
//  6 reset at 5th C_DRAIN result -> all outputs 0 next edge; a new req=4'b0010 is granted normally after release.

Source files
------------

// File: rtl/gsim_job_scheduler.sv
// rtl/gsim_job_scheduler.sv - round-robin front end for the 16-unknown Gauss-Seidel core
// Optional watchdog in C_WAIT enabled by defining GSIM_SCHED_TIMEOUT_EN.
module gsim_job_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 2048
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*16-1:0] req_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   req_pop,
    output logic                 core_reset,
    output logic                 core_in_en,
    output logic [15:0]          core_b_in,
    input  logic                 core_out_valid,
    input  logic [31:0]          core_x_out,
    output logic                 res_valid,
    output logic [ID_W-1:0]      res_id,
    output logic [3:0]           res_idx,
    output logic [31:0]          res_x,
    output logic                 busy,
    output logic                 err
);

    typedef enum logic [1:0] {F_IDLE, F_FILL, F_FULL} fstate_t;
    typedef enum logic [1:0] {C_IDLE, C_FEED, C_WAIT, C_DRAIN} cstate_t;

    fstate_t         fstate;
    cstate_t         cstate;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rr_win;
    logic            rr_found;
    logic [ID_W-1:0] fill_id;
    logic [ID_W-1:0] job_id;
    logic [3:0]      fill_cnt;
    logic [3:0]      feed_cnt;
    logic [3:0]      drain_cnt;
    logic [15:0]     buf_mem [16];
    logic            buf_release;

    // The core loads and emits in interleaved order: position k maps to x index {k[1:0],k[3:2]}.
    function automatic logic [3:0] perm(input logic [3:0] k);
        return {k[1:0], k[3:2]};
    endfunction

    always_comb begin
        int j;
        j        = 0;
        rr_found = 1'b0;
        rr_win   = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(rr_ptr) + i) % NUM_REQ;
            if (!rr_found && req[j]) begin
                rr_found = 1'b1;
                rr_win   = ID_W'(j);
            end
        end
    end

    // feed_cnt wraps to 0 on the 16th feed cycle.
    assign buf_release = (cstate == C_FEED) && (feed_cnt == 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fstate   <= F_IDLE;
            grant    <= '0;
            req_pop  <= '0;
            rr_ptr   <= '0;
            fill_id  <= '0;
            fill_cnt <= '0;
        end else begin
            case (fstate)
                F_IDLE: begin
                    if (rr_found) begin
                        fstate   <= F_FILL;
                        grant    <= NUM_REQ'(1) << rr_win;
                        req_pop  <= NUM_REQ'(1) << rr_win;
                        fill_id  <= rr_win;
                        rr_ptr   <= ID_W'((int'(rr_win) + 1) % NUM_REQ);
                        fill_cnt <= '0;
                    end
                end
                F_FILL: begin
                    fill_cnt <= fill_cnt + 4'd1;
                    if (fill_cnt == 4'd15) begin
                        fstate  <= F_FULL;
                        grant   <= '0;
                        req_pop <= '0;
                    end
                end
                F_FULL: begin
                    if (buf_release)
                        fstate <= F_IDLE;
                end
                default: fstate <= F_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fstate == F_FILL)
            buf_mem[fill_cnt] <= req_data[{fill_id, 4'b0000} +: 16];
    end

`ifdef GSIM_SCHED_TIMEOUT_EN
    logic [15:0] wd;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cstate     <= C_IDLE;
            core_in_en <= 1'b0;
            core_b_in  <= '0;
            feed_cnt   <= '0;
            drain_cnt  <= '0;
            job_id     <= '0;
            res_valid  <= 1'b0;
            res_id     <= '0;
            res_idx    <= '0;
            res_x      <= '0;
`ifdef GSIM_SCHED_TIMEOUT_EN
            wd         <= '0;
            err        <= 1'b0;
            core_reset <= 1'b0;
`endif
        end else begin
            res_valid <= 1'b0;
`ifdef GSIM_SCHED_TIMEOUT_EN
            err        <= 1'b0;
            core_reset <= 1'b0;
`endif
            case (cstate)
                C_IDLE: begin
                    if (fstate == F_FULL) begin
                        cstate     <= C_FEED;
                        job_id     <= fill_id;
                        core_in_en <= 1'b1;
                        core_b_in  <= buf_mem[0];
                        feed_cnt   <= 4'd1;
                    end
                end
                C_FEED: begin
                    feed_cnt <= feed_cnt + 4'd1;
                    if (feed_cnt == 4'd0) begin
                        core_in_en <= 1'b0;
                        core_b_in  <= '0;
                        cstate     <= C_WAIT;
`ifdef GSIM_SCHED_TIMEOUT_EN
                        wd         <= '0;
`endif
                    end else begin
                        core_b_in <= buf_mem[perm(feed_cnt)];
                    end
                end
                C_WAIT: begin
                    if (core_out_valid) begin
                        cstate    <= C_DRAIN;
                        res_valid <= 1'b1;
                        res_id    <= job_id;
                        res_idx   <= 4'd0;
                        res_x     <= core_x_out;
                        drain_cnt <= 4'd1;
                    end
`ifdef GSIM_SCHED_TIMEOUT_EN
                    else if (wd == 16'(TIMEOUT - 1)) begin
                        err        <= 1'b1;
                        core_reset <= 1'b1;
                        cstate     <= C_IDLE;
                    end else begin
                        wd <= wd + 16'd1;
                    end
`endif
                end
                C_DRAIN: begin
                    if (core_out_valid) begin
                        res_valid <= 1'b1;
                        res_id    <= job_id;
                        res_idx   <= perm(drain_cnt);
                        res_x     <= core_x_out;
                        drain_cnt <= drain_cnt + 4'd1;
                        if (drain_cnt == 4'd15)
                            cstate <= C_IDLE;
                    end
                end
                default: cstate <= C_IDLE;
            endcase
        end
    end

`ifndef GSIM_SCHED_TIMEOUT_EN
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign err            = 1'b0;
    assign core_reset     = 1'b0;
`endif

    assign busy = (fstate != F_IDLE) || (cstate != C_IDLE) || res_valid;

endmodule

// File: tb/tb_gsim_job_scheduler.sv
// tb/tb_gsim_job_scheduler.sv - scoreboard bench for gsim_job_scheduler
module tb_gsim_job_scheduler;
    localparam int NUM_REQ = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [63:0]  req_data;
    logic [3:0]   grant, req_pop;
    logic         core_reset, core_in_en;
    logic [15:0]  core_b_in;
    logic         core_out_valid;
    logic [31:0]  core_x_out;
    logic         res_valid;
    logic [1:0]   res_id;
    logic [3:0]   res_idx;
    logic [31:0]  res_x;
    logic         busy, err;

    gsim_job_scheduler #(.NUM_REQ(4), .ID_W(2), .TIMEOUT(64)) dut (
        .clk(clk), .reset(rst), .req(req), .req_data(req_data),
        .grant(grant), .req_pop(req_pop), .core_reset(core_reset),
        .core_in_en(core_in_en), .core_b_in(core_b_in),
        .core_out_valid(core_out_valid), .core_x_out(core_x_out),
        .res_valid(res_valid), .res_id(res_id), .res_idx(res_idx), .res_x(res_x),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { int id; int idx; logic [31:0] x; } res_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] word_cnt [NUM_REQ] = '{default: 16'd0};
    logic [15:0] fill_words [16];
    int          fill_n, fill_id_m;
    logic [15:0] feed_q [$];
    int          job_q [$];
    res_t        res_q [$];
    int          grant_q [$];
    logic [3:0]  prev_grant;
    int          load_cnt, cur_id, resp_id, pending_wait, out_left, job_seq;
    int          feeds_done;
    int          res_count = 0;
    bit          core_respond = 1'b1;
    int          core_lat = 3;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int tperm(input int k);
        return (k % 4) * 4 + k / 4;
    endfunction

    // Requester i presents words i*1000+1, i*1000+2, ... advancing on each pop.
    always @(posedge clk)
        for (int i = 0; i < NUM_REQ; i++)
            if (req_pop[i]) word_cnt[i] <= word_cnt[i] + 16'd1;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_data[16*i +: 16] = 16'(i * 1000 + 1) + word_cnt[i];
    end

    // Scoreboard plus a behavioural solver core, all evaluated on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            feed_q.delete(); job_q.delete(); res_q.delete(); grant_q.delete();
            fill_n = 0; load_cnt = 0; pending_wait = 0; out_left = 0;
            job_seq = 0; feeds_done = 0; prev_grant = '0;
            core_out_valid = 1'b0; core_x_out = '0;
        end else begin
            if (grant != 4'b0 && prev_grant == 4'b0)
                for (int i = 0; i < NUM_REQ; i++) if (grant[i]) grant_q.push_back(i);
            prev_grant = grant;
            check("req_pop_vs_grant", 64'(req_pop), 64'(grant));

            for (int i = 0; i < NUM_REQ; i++)
                if (req_pop[i]) begin
                    fill_words[fill_n] = req_data[16*i +: 16];
                    fill_id_m = i;
                    fill_n++;
                end
            if (fill_n == 16) begin
                for (int k = 0; k < 16; k++) feed_q.push_back(fill_words[tperm(k)]);
                job_q.push_back(fill_id_m);
                fill_n = 0;
            end

            if (res_valid) begin
                res_t r;
                res_count++;
                if (res_q.size() == 0) begin
                    check("res_unexpected", 64'(res_valid), 64'd0);
                end else begin
                    r = res_q.pop_front();
                    check("res_id", 64'(res_id), 64'(r.id));
                    check("res_idx", 64'(res_idx), 64'(r.idx));
                    check("res_x", 64'(res_x), 64'(r.x));
                end
            end

            core_out_valid = 1'b0;
            if (pending_wait > 0) begin
                pending_wait--;
                if (pending_wait == 0) out_left = 16;
            end
            if (out_left > 0) begin
                int k;
                k = 16 - out_left;
                core_out_valid = 1'b1;
                core_x_out = 32'(100 + 16 * job_seq + k);
                res_q.push_back('{resp_id, tperm(k), core_x_out});
                out_left--;
                if (out_left == 0) job_seq++;
            end

            if (core_in_en) begin
                if (load_cnt == 0) cur_id = (job_q.size() > 0) ? job_q.pop_front() : -1;
                if (feed_q.size() == 0) check("feed_unexpected", 64'(core_in_en), 64'd0);
                else check("feed_word", 64'(core_b_in), 64'(feed_q.pop_front()));
                load_cnt++;
                if (load_cnt == 16) begin
                    load_cnt = 0;
                    feeds_done++;
                    if (core_respond) begin
                        pending_wait = core_lat;
                        resp_id = cur_id;
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (grant != 4'b0) return;
            step();
        end
        check(tag, 64'(grant != 4'b0), 64'd1);
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            step();
            if (!busy && res_q.size() == 0 && out_left == 0 && pending_wait == 0 && feed_q.size() == 0)
                return;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic wait_feeds(input int n);
        for (int i = 0; i < 200; i++) begin
            if (feeds_done >= n) return;
            step();
        end
        check("feed_timeout", 64'(feeds_done), 64'(n));
    endtask

    initial begin
        int n, base;
        rst = 1'b1;
        req = 4'b0;
        step(); step(); step();
        check("reset_outputs", 64'(|{grant, req_pop, core_reset, core_in_en, core_b_in, res_valid,
                                       res_id, res_idx, res_x, busy, err}), 64'd0);
        rst = 1'b0;

        // single job from requester 0, words 1..16
        base = res_count;
        req = 4'b0001;
        wait_grant("t1_grant_timeout");
        check("t1_grant", 64'(grant), 64'h1);
        req = 4'b0000;
        n = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (grant == 4'b0) break;
            n++;
        end
        check("t1_grant_len", 64'(n), 64'd16);
        wait_idle("t1_idle_timeout", 400);
        check("t1_results", 64'(res_count - base), 64'd16);

        // fairness with all four requesting
        do_reset();
        base = res_count;
        req = 4'b1111;
        for (int i = 0; i < 2000; i++) begin
            if (grant_q.size() >= 8) break;
            step();
        end
        req = 4'b0000;
        check("t2_grant_count", 64'(grant_q.size() >= 8), 64'd1);
        wait_idle("t2_idle_timeout", 800);
        if (grant_q.size() >= 8)
            for (int i = 0; i < 8; i++) check("t2_order", 64'(grant_q[i]), 64'(i % 4));
        check("t2_results", 64'(res_count - base), 64'd128);

        // overlap: B staged during A's wait, fed the cycle after A's last result
        do_reset();
        core_lat = 40;
        req = 4'b0001;
        wait_feeds(1);
        req = 4'b0100;
        wait_grant("t3_grant_timeout");
        check("t3_grant", 64'(grant), 64'h4);
        req = 4'b0000;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (res_valid) n++;
            if (n == 16) break;
        end
        check("t3_a_results", 64'(n), 64'd16);
        check("t3_b_staged", 64'(job_q.size()), 64'd1);
        check("t3_no_early_feed", 64'(core_in_en), 64'd0);
        step();
        check("t3_feed_next", 64'(core_in_en), 64'd1);
        wait_idle("t3_idle_timeout", 400);
        core_lat = 3;

`ifdef GSIM_SCHED_TIMEOUT_EN
        // watchdog: core never answers
        do_reset();
        core_respond = 1'b0;
        req = 4'b0001;
        wait_feeds(1);
        req = 4'b0000;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            n++;
            if (err) break;
        end
        check("t5_err_delay", 64'(n), 64'd65);
        check("t5_core_reset", 64'(core_reset), 64'd1);
        step();
        check("t5_err_pulse", 64'(err), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        core_respond = 1'b1;
        wait_idle("t5_idle_timeout", 100);
`endif

        // reset at the fifth result, then a fresh request from requester 1
        do_reset();
        base = res_count;
        req = 4'b0001;
        for (int i = 0; i < 300; i++) begin
            if (res_count - base == 5) break;
            step();
        end
        req = 4'b0000;
        check("t6_five_results", 64'(res_count - base), 64'd5);
        #2 rst = 1'b1;
        #1;
        check("t6_outputs_cleared", 64'(|{grant, req_pop, core_reset, core_in_en, core_b_in, res_valid,
                                          res_id, res_idx, res_x, busy, err}), 64'd0);
        step();
        step();
        rst = 1'b0;
        base = res_count;
        req = 4'b0010;
        wait_grant("t6_grant_timeout");
        check("t6_grant", 64'(grant), 64'h2);
        req = 4'b0000;
        wait_idle("t6_idle_timeout", 400);
        check("t6_results", 64'(res_count - base), 64'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
